// File: rtl/irq_source_decoder.sv
// Receiving end of a wired-OR interrupt line with two raw sources (A, B).
// Each source is synchronized and edge-detected into a sticky pending bit.
// A small FSM presents one request at a time, round-robins between the two
// sources, and waits for ACK or a wait-counter timeout before moving on.
// Overrun and timeout conditions are reported as sticky flags.
module irq_source_decoder #(
  parameter int SYNC_STAGES = 2,   // synchronizer depth per raw input, 2..4
  parameter int TIMEOUT     = 255  // ACTIVE cycles without ACK before abandon, 1..255
) (
  input  logic       CLK,
  input  logic       R,
  input  logic       IRQ_A,
  input  logic       IRQ_B,
  input  logic [1:0] MASK,
  input  logic       ACK,
  input  logic       CLR_ERR,
  output logic       IRQ_OUT,
  output logic [1:0] SRC,
  output logic [1:0] PEND,
  output logic       OVR,
  output logic       TMO
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  // After reset release the synchronizer fills with whatever the raw inputs
  // hold; edges are ignored until the delayed copy has caught up so that an
  // input held high through reset does not look like a fresh rising edge.
  localparam logic [2:0] WARM_DONE  = 3'(SYNC_STAGES + 1);
  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] r_sync_a;
  logic [SYNC_STAGES-1:0] r_sync_b;
  logic                   r_dly_a;
  logic                   r_dly_b;
  logic [2:0]             r_warm;

  state_t     r_state;
  logic [1:0] r_src;
  logic       r_irq;
  logic [1:0] r_pend;
  logic       r_ovr;
  logic       r_tmo;
  logic [7:0] r_wait;
  logic       r_prefer_b;

  logic       w_armed;
  logic [1:0] w_edge;
  logic [1:0] w_elig;
  logic [1:0] w_pick;
  logic       w_timeout;
  logic       w_done;
  logic [1:0] w_clr;
  logic [1:0] w_pend_nxt;
  logic       w_ovr_set;

  state_t     w_state_nxt;
  logic [1:0] w_src_nxt;
  logic       w_irq_nxt;
  logic [7:0] w_wait_nxt;
  logic       w_prefer_b_nxt;

  // Synchronizers, one-cycle delayed copies and the post-reset warm-up count.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the shift chain work.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      r_sync_a <= '0;
      r_sync_b <= '0;
      r_dly_a  <= 1'b0;
      r_dly_b  <= 1'b0;
      r_warm   <= '0;
    end else begin
      r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], IRQ_A};
      r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], IRQ_B};
      r_dly_a  <= r_sync_a[SYNC_STAGES-1];
      r_dly_b  <= r_sync_b[SYNC_STAGES-1];
      if (r_warm != WARM_DONE) r_warm <= r_warm + 3'd1;
    end
  end

  assign w_armed   = (r_warm == WARM_DONE);
  assign w_edge[0] = w_armed & r_sync_a[SYNC_STAGES-1] & ~r_dly_a;
  assign w_edge[1] = w_armed & r_sync_b[SYNC_STAGES-1] & ~r_dly_b;

  // Request completion: ACK wins over a timeout landing in the same cycle.
  assign w_timeout = (r_state == ST_ACTIVE) && !ACK && (r_wait == TIMEOUT_M1);
  assign w_done    = (r_state == ST_ACTIVE) && (ACK || w_timeout);
  assign w_clr     = w_done ? r_src : 2'b00;

  // A new edge always sets pending; it is an overrun only if the bit was
  // already set and is not being retired on this same edge.
  assign w_pend_nxt = w_edge | (r_pend & ~w_clr);
  assign w_ovr_set  = |(w_edge & r_pend & ~w_clr);

  // Round-robin choice among unmasked pending sources.
  assign w_elig = r_pend & ~MASK;
  assign w_pick = (w_elig == 2'b11) ? (r_prefer_b ? 2'b10 : 2'b01) : w_elig;

  // Next-state and next-output decode for the presentation FSM.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_src_nxt      = r_src;
    w_irq_nxt      = r_irq;
    w_wait_nxt     = r_wait;
    w_prefer_b_nxt = r_prefer_b;
    unique case (r_state)
      ST_IDLE: begin
        if (|w_elig) begin
          w_state_nxt    = ST_ACTIVE;
          w_src_nxt      = w_pick;
          w_irq_nxt      = 1'b1;
          w_wait_nxt     = 8'd0;
          w_prefer_b_nxt = w_pick[0];
        end
      end
      ST_ACTIVE: begin
        if (w_done) begin
          w_state_nxt = ST_GAP;
          w_src_nxt   = 2'b00;
          w_irq_nxt   = 1'b0;
        end else begin
          w_wait_nxt = r_wait + 8'd1;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_src_nxt   = 2'b00;
        w_irq_nxt   = 1'b0;
      end
    endcase
  end

  // FSM, request outputs, pending bits and sticky error flags.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      r_state    <= ST_IDLE;
      r_src      <= 2'b00;
      r_irq      <= 1'b0;
      r_wait     <= 8'd0;
      r_prefer_b <= 1'b0;
      r_pend     <= 2'b00;
      r_ovr      <= 1'b0;
      r_tmo      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_src      <= w_src_nxt;
      r_irq      <= w_irq_nxt;
      r_wait     <= w_wait_nxt;
      r_prefer_b <= w_prefer_b_nxt;
      r_pend     <= w_pend_nxt;
      r_ovr      <= w_ovr_set | (r_ovr & ~CLR_ERR);
      r_tmo      <= w_timeout | (r_tmo & ~CLR_ERR);
    end
  end

  assign IRQ_OUT = r_irq;
  assign SRC     = r_src;
  assign PEND    = r_pend;
  assign OVR     = r_ovr;
  assign TMO     = r_tmo;

endmodule

// File: tb/tb_irq_source_decoder.sv
// Testbench for irq_source_decoder: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model that works from
// the recorded raw-input history rather than from flop-level structure.
module tb_irq_source_decoder;

  localparam int S = 2;
  localparam int T = 3;

  logic       CLK = 1'b0;
  logic       R = 1'b0;
  logic       IRQ_A = 1'b0;
  logic       IRQ_B = 1'b0;
  logic [1:0] MASK = 2'b00;
  logic       ACK = 1'b0;
  logic       CLR_ERR = 1'b0;
  logic       IRQ_OUT;
  logic [1:0] SRC;
  logic [1:0] PEND;
  logic       OVR;
  logic       TMO;

  irq_source_decoder #(.SYNC_STAGES(S), .TIMEOUT(T)) dut (
    .CLK    (CLK),
    .R      (R),
    .IRQ_A  (IRQ_A),
    .IRQ_B  (IRQ_B),
    .MASK   (MASK),
    .ACK    (ACK),
    .CLR_ERR(CLR_ERR),
    .IRQ_OUT(IRQ_OUT),
    .SRC    (SRC),
    .PEND   (PEND),
    .OVR    (OVR),
    .TMO    (TMO)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state.
  bit       ha[$];
  bit       hb[$];
  bit [1:0] m_pend;
  bit       m_ovr;
  bit       m_tmo;
  int       m_mode;      // 0 = waiting, 1 = presenting, 2 = gap
  int       m_served;    // 0 = A, 1 = B
  int       m_waited;
  bit       m_prefer_b;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    ha.delete();
    hb.delete();
    m_pend     = 2'b00;
    m_ovr      = 1'b0;
    m_tmo      = 1'b0;
    m_mode     = 0;
    m_served   = 0;
    m_waited   = 0;
    m_prefer_b = 1'b0;
  endtask

  // A rise is seen at edge n when the raw input sampled S edges earlier was 1
  // and the one before it was 0; the first S+1 edges after reset see nothing.
  function automatic bit rise_seen(input bit h[$]);
    int n;
    n = h.size();
    if (n < S + 2) return 1'b0;
    return h[n-S-1] && !h[n-S-2];
  endfunction

  task automatic model_step();
    bit [1:0] e;
    bit [1:0] clr;
    bit [1:0] elig;
    bit [1:0] new_pend;
    bit       fire;
    bit       done;
    bit       ovr_set;
    ha.push_back(IRQ_A);
    hb.push_back(IRQ_B);
    e[0] = rise_seen(ha);
    e[1] = rise_seen(hb);
    fire = (m_mode == 1) && !ACK && (m_waited + 1 == T);
    done = (m_mode == 1) && (ACK || fire);
    clr  = 2'b00;
    if (done) clr[m_served] = 1'b1;
    ovr_set = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (e[i] && m_pend[i] && !clr[i]) ovr_set = 1'b1;
      new_pend[i] = e[i] || (m_pend[i] && !clr[i]);
    end
    elig = m_pend & ~MASK;
    case (m_mode)
      0: if (elig != 2'b00) begin
        if (elig == 2'b11) m_served = m_prefer_b ? 1 : 0;
        else               m_served = elig[1] ? 1 : 0;
        m_prefer_b = (m_served == 0);
        m_mode     = 1;
        m_waited   = 0;
      end
      1: if (done) m_mode = 2;
         else      m_waited++;
      default: m_mode = 0;
    endcase
    m_pend = new_pend;
    m_ovr  = ovr_set || (m_ovr && !CLR_ERR);
    m_tmo  = fire || (m_tmo && !CLR_ERR);
  endtask

  task automatic check_all();
    logic [1:0] exp_src;
    exp_src = (m_mode == 1) ? ((m_served == 1) ? 2'b10 : 2'b01) : 2'b00;
    check("irq_out", 8'(IRQ_OUT), 8'(m_mode == 1));
    check("src",     8'(SRC),     8'(exp_src));
    check("pend",    8'(PEND),    8'(m_pend));
    check("ovr",     8'(OVR),     8'(m_ovr));
    check("tmo",     8'(TMO),     8'(m_tmo));
  endtask

  // Called at a falling edge: one rising edge, model update, compare, back to falling edge.
  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    check_all();
    @(negedge CLK);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset pulse between clock edges, checked with no edge in between.
  task automatic do_reset();
    R = 1'b0;
    #1;
    model_reset();
    check_all();
    #1;
    R = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge CLK);
    #1;
    check("rst_irq",  8'(IRQ_OUT), 8'h0);
    check("rst_pend", 8'(PEND),    8'h0);
    check_all();
    R = 1'b1;
    ticks(5);

    // Single event: four edges of latency, ACK, one gap cycle.
    IRQ_A = 1'b1;
    ticks(3);
    check("lat_irq_early", 8'(IRQ_OUT), 8'h0);
    tick();
    check("lat_irq", 8'(IRQ_OUT), 8'h1);
    check("lat_src", 8'(SRC),     8'h1);
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    check("ack_irq",  8'(IRQ_OUT), 8'h0);
    check("ack_pend", 8'(PEND),    8'h0);
    tick();
    check("gap_irq", 8'(IRQ_OUT), 8'h0);
    IRQ_A = 1'b0;
    ticks(3);

    // Simultaneous A and B after reset: A first, then B.
    do_reset();
    ticks(5);
    IRQ_A = 1'b1;
    IRQ_B = 1'b1;
    ticks(4);
    check("rr_first", 8'(SRC), 8'h1);
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    ticks(2);
    check("rr_second", 8'(SRC), 8'h2);
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    check("rr_pend", 8'(PEND), 8'h0);
    IRQ_A = 1'b0;
    IRQ_B = 1'b0;
    ticks(3);

    // Masked capture, then unmask.
    MASK = 2'b01;
    IRQ_A = 1'b1;
    ticks(3);
    check("mask_pend", 8'(PEND), 8'h1);
    IRQ_A = 1'b0;
    ticks(3);
    check("mask_irq", 8'(IRQ_OUT), 8'h0);
    MASK = 2'b00;
    tick();
    check("unmask_irq", 8'(IRQ_OUT), 8'h1);
    check("unmask_src", 8'(SRC),     8'h1);
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    ticks(3);

    // Timeout after T ACTIVE cycles, then clear.
    IRQ_A = 1'b1;
    ticks(4);
    IRQ_A = 1'b0;
    ticks(2);
    check("tmo_early", 8'(TMO), 8'h0);
    tick();
    check("tmo_set",  8'(TMO),     8'h1);
    check("tmo_pend", 8'(PEND),    8'h0);
    check("tmo_irq",  8'(IRQ_OUT), 8'h0);
    tick();
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    check("tmo_clr", 8'(TMO), 8'h0);
    ticks(3);

    // Overrun: second A rise while the first is still pending.
    IRQ_A = 1'b1;
    tick();
    IRQ_A = 1'b0;
    tick();
    IRQ_A = 1'b1;
    ticks(3);
    check("ovr_set", 8'(OVR),     8'h1);
    check("ovr_irq", 8'(IRQ_OUT), 8'h1);
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    IRQ_A = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("ovr_single", 8'(IRQ_OUT), 8'h0);
    end
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    check("ovr_clr", 8'(OVR), 8'h0);

    // Reset mid-ACTIVE with IRQ_A held high through release.
    IRQ_A = 1'b1;
    ticks(4);
    check("pre_rst_irq", 8'(IRQ_OUT), 8'h1);
    R = 1'b0;
    #1;
    check("async_irq",  8'(IRQ_OUT), 8'h0);
    check("async_pend", 8'(PEND),    8'h0);
    model_reset();
    @(negedge CLK);
    R = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("held_no_req", 8'(IRQ_OUT), 8'h0);
    end
    IRQ_A = 1'b0;
    ticks(3);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) IRQ_A = ~IRQ_A;
      if ($urandom_range(0, 3) == 0) IRQ_B = ~IRQ_B;
      if ($urandom_range(0, 15) == 0) MASK = 2'($urandom);
      ACK     = ($urandom_range(0, 3) == 0);
      CLR_ERR = ($urandom_range(0, 9) == 0);
      if (i == 400) do_reset();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
